// File: rtl/phold_pkg.sv
// Shared PHOLD definitions: MC command codes, requester-ID sizing and the
// state encoding of the MC port lock FSM.
package phold_pkg;

    // Convey MC request command codes used by PHOLD requesters
    localparam logic [2:0] MC_CMD_RD   = 3'd1;
    localparam logic [2:0] MC_CMD_WR   = 3'd2;
    localparam logic [3:0] MC_SCMD_NUL = 4'd0;

    // Requester-ID field width carried in rtnctl MSBs; never narrower than 1 bit
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // MC port ownership: open round-robin or held by one requester
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/phold_mc_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping mod N.
// Shared by the MC port arbiter and the event queue.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int unsigned j;

    // Scan from ptr upward, take the first live request
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (en && !any && (|(req & (N'(1) << j)))) begin
                gnt     = N'(1) << j;
                gnt_idx = IW'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phold_mc_arbiter.sv
// Shares one Convey MC port between NUM_REQ PHOLD requesters: round-robin
// grant with optional lock, requester ID tagged into rtnctl MSBs, responses
// routed back by that tag.
module phold_mc_arbiter
    import phold_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned RTNCTL_WIDTH = 32,
    parameter  int unsigned ID_W         = id_w(NUM_REQ),
    localparam int unsigned UW           = RTNCTL_WIDTH - ID_W
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [3*NUM_REQ-1:0]      req_cmd,
    input  logic [4*NUM_REQ-1:0]      req_scmd,
    input  logic [2*NUM_REQ-1:0]      req_size,
    input  logic [48*NUM_REQ-1:0]     req_vadr,
    input  logic [64*NUM_REQ-1:0]     req_data,
    input  logic [UW*NUM_REQ-1:0]     req_rtnctl,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic                      mc_rq_vld,
    output logic [2:0]                mc_rq_cmd,
    output logic [3:0]                mc_rq_scmd,
    output logic [1:0]                mc_rq_size,
    output logic [47:0]               mc_rq_vadr,
    output logic [63:0]               mc_rq_data,
    output logic [RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
    input  logic                      mc_rq_stall,
    input  logic                      mc_rs_vld,
    input  logic [2:0]                mc_rs_cmd,
    input  logic [3:0]                mc_rs_scmd,
    input  logic [63:0]               mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
    output logic                      mc_rs_stall,
    output logic [NUM_REQ-1:0]        rs_vld,
    output logic [2:0]                rs_cmd,
    output logic [3:0]                rs_scmd,
    output logic [63:0]               rs_data,
    output logic [UW-1:0]             rs_rtnctl,
    input  logic [NUM_REQ-1:0]        rs_stall,
    output logic [63:0]               arb_stalls
);

    arb_state_t         state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt, owner, owner_nxt;
    logic               r_stall;
    logic               arb_en;
    logic [NUM_REQ-1:0] rr_gnt, owner_oh;
    logic [ID_W-1:0]    rr_idx;
    logic               rr_any;
    logic               xfer;
    logic [ID_W-1:0]    xfer_idx;
    logic [ID_W-1:0]    rs_id;
    logic [NUM_REQ-1:0] rs_hit;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] i);
        if (32'(i) + 32'd1 >= NUM_REQ) begin
            return '0;
        end
        return i + ID_W'(1);
    endfunction

    assign arb_en   = (state == ARB) && !r_stall && !i_reset;
    assign owner_oh = NUM_REQ'(1) << owner;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req     (req_vld),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // Lock FSM next state, pointer update and the one-hot accept
    always_comb begin
        req_rdy   = '0;
        xfer      = 1'b0;
        xfer_idx  = owner;
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        case (state)
            ARB: begin
                req_rdy  = rr_gnt;
                xfer     = rr_any;
                xfer_idx = rr_idx;
                if (rr_any) begin
                    ptr_nxt = next_ptr(rr_idx);
                    if (|(req_lock & rr_gnt)) begin
                        state_nxt = LOCKED;
                        owner_nxt = rr_idx;
                    end
                end
            end
            LOCKED: begin
                if ((|(req_vld & owner_oh)) && !r_stall && !i_reset) begin
                    req_rdy = owner_oh;
                    xfer    = 1'b1;
                    if (!(|(req_lock & owner_oh))) begin
                        state_nxt = ARB;
                        ptr_nxt   = next_ptr(owner);
                    end
                end else if (!(|(req_lock & owner_oh)) && !(|(req_vld & owner_oh))) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Lock FSM state, round-robin pointer, owner and registered MC stall
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ARB;
            ptr     <= '0;
            owner   <= '0;
            r_stall <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            r_stall <= mc_rq_stall;
        end
    end

    // MC request register: winner's fields one cycle after transfer
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            mc_rq_vld    <= 1'b0;
            mc_rq_cmd    <= '0;
            mc_rq_scmd   <= '0;
            mc_rq_size   <= '0;
            mc_rq_vadr   <= '0;
            mc_rq_data   <= '0;
            mc_rq_rtnctl <= '0;
        end else begin
            mc_rq_vld <= xfer;
            if (xfer) begin
                mc_rq_cmd    <= req_cmd[xfer_idx*3 +: 3];
                mc_rq_scmd   <= req_scmd[xfer_idx*4 +: 4];
                mc_rq_size   <= req_size[xfer_idx*2 +: 2];
                mc_rq_vadr   <= req_vadr[xfer_idx*48 +: 48];
                mc_rq_data   <= req_data[xfer_idx*64 +: 64];
                mc_rq_rtnctl <= {xfer_idx, req_rtnctl[xfer_idx*UW +: UW]};
            end
        end
    end

    // IDs at or above NUM_REQ shift the one-hot out of range, dropping the response
    assign rs_id  = mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W];
    assign rs_hit = mc_rs_vld ? (NUM_REQ'(1) << rs_id) : '0;

    // Response demux register and response back-pressure
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rs_vld      <= '0;
            rs_cmd      <= '0;
            rs_scmd     <= '0;
            rs_data     <= '0;
            rs_rtnctl   <= '0;
            mc_rs_stall <= 1'b0;
        end else begin
            rs_vld      <= rs_hit;
            mc_rs_stall <= |rs_stall;
            if (mc_rs_vld) begin
                rs_cmd    <= mc_rs_cmd;
                rs_scmd   <= mc_rs_scmd;
                rs_data   <= mc_rs_data;
                rs_rtnctl <= mc_rs_rtnctl[UW-1:0];
            end
        end
    end

    // Saturating count of cycles with pending requests and no grant
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            arb_stalls <= '0;
        end else if ((|req_vld) && !(|req_rdy) && (arb_stalls != '1)) begin
            arb_stalls <= arb_stalls + 64'd1;
        end
    end

endmodule

// File: tb/tb_phold_mc_arbiter.sv
// Self-checking bench for phold_mc_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of grant order, lock, request/response routing.
module tb_phold_mc_arbiter;
    import phold_pkg::*;

    localparam int N  = 4;
    localparam int RW = 32;
    localparam int IW = 3;   // wider than needed so out-of-range IDs exist
    localparam int UW = RW - IW;

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic [N-1:0]      req_vld = '0, req_lock = '0;
    logic [3*N-1:0]    req_cmd = '0;
    logic [4*N-1:0]    req_scmd = '0;
    logic [2*N-1:0]    req_size = '0;
    logic [48*N-1:0]   req_vadr = '0;
    logic [64*N-1:0]   req_data = '0;
    logic [UW*N-1:0]   req_rtnctl = '0;
    logic [N-1:0]      req_rdy;
    logic              mc_rq_vld;
    logic [2:0]        mc_rq_cmd;
    logic [3:0]        mc_rq_scmd;
    logic [1:0]        mc_rq_size;
    logic [47:0]       mc_rq_vadr;
    logic [63:0]       mc_rq_data;
    logic [RW-1:0]     mc_rq_rtnctl;
    logic              mc_rq_stall = 1'b0;
    logic              mc_rs_vld = 1'b0;
    logic [2:0]        mc_rs_cmd = '0;
    logic [3:0]        mc_rs_scmd = '0;
    logic [63:0]       mc_rs_data = '0;
    logic [RW-1:0]     mc_rs_rtnctl = '0;
    logic              mc_rs_stall;
    logic [N-1:0]      rs_vld;
    logic [2:0]        rs_cmd;
    logic [3:0]        rs_scmd;
    logic [63:0]       rs_data;
    logic [UW-1:0]     rs_rtnctl;
    logic [N-1:0]      rs_stall = '0;
    logic [63:0]       arb_stalls;

    phold_mc_arbiter #(
        .NUM_REQ      (N),
        .RTNCTL_WIDTH (RW),
        .ID_W         (IW)
    ) dut (
        .clk(clk), .i_reset(i_reset),
        .req_vld(req_vld), .req_lock(req_lock), .req_cmd(req_cmd), .req_scmd(req_scmd),
        .req_size(req_size), .req_vadr(req_vadr), .req_data(req_data), .req_rtnctl(req_rtnctl),
        .req_rdy(req_rdy),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_size(mc_rq_size), .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data),
        .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
        .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
        .rs_vld(rs_vld), .rs_cmd(rs_cmd), .rs_scmd(rs_scmd), .rs_data(rs_data),
        .rs_rtnctl(rs_rtnctl), .rs_stall(rs_stall), .arb_stalls(arb_stalls)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // ---------------- behavioural model ----------------
    int          m_ptr, m_owner;
    bit          m_locked, m_rstall;
    logic [63:0] m_stalls;
    int          grant_log[$];

    logic          e_mc_vld;
    logic [2:0]    e_cmd;
    logic [3:0]    e_scmd;
    logic [1:0]    e_size;
    logic [47:0]   e_vadr;
    logic [63:0]   e_data;
    logic [RW-1:0] e_rtnctl;
    logic [N-1:0]  e_rs_vld;
    logic [2:0]    e_rs_cmd;
    logic [3:0]    e_rs_scmd;
    logic [63:0]   e_rs_data;
    logic [UW-1:0] e_rs_rtnctl;
    logic          e_mc_rs_stall;

    // Who may transfer this cycle, straight from the arbitration rules
    function automatic int pick();
        if (m_rstall) return -1;
        if (m_locked) return bitof(req_vld, m_owner) ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (bitof(req_vld, (m_ptr + k) % N)) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : chk
        int g, id;
        logic [N-1:0] exp_rdy;
        if (i_reset) begin
            check("rst_mc_rq_vld", mc_rq_vld, 0);
            check("rst_rs_vld", rs_vld, 0);
            check("rst_req_rdy", req_rdy, 0);
            check("rst_mc_rs_stall", mc_rs_stall, 0);
            check("rst_arb_stalls", arb_stalls, 0);
            m_ptr = 0; m_owner = 0; m_locked = 0; m_rstall = 0; m_stalls = '0;
            e_mc_vld = 0; e_cmd = '0; e_scmd = '0; e_size = '0; e_vadr = '0;
            e_data = '0; e_rtnctl = '0; e_rs_vld = '0; e_rs_cmd = '0; e_rs_scmd = '0;
            e_rs_data = '0; e_rs_rtnctl = '0; e_mc_rs_stall = 0;
        end else begin
            check("mc_rq_vld", mc_rq_vld, e_mc_vld);
            if (e_mc_vld) begin
                check("mc_rq_cmd", mc_rq_cmd, e_cmd);
                check("mc_rq_scmd", mc_rq_scmd, e_scmd);
                check("mc_rq_size", mc_rq_size, e_size);
                check("mc_rq_vadr", mc_rq_vadr, e_vadr);
                check("mc_rq_data", mc_rq_data, e_data);
                check("mc_rq_rtnctl", mc_rq_rtnctl, e_rtnctl);
            end
            check("rs_vld", rs_vld, e_rs_vld);
            if (e_rs_vld != '0) begin
                check("rs_cmd", rs_cmd, e_rs_cmd);
                check("rs_scmd", rs_scmd, e_rs_scmd);
                check("rs_data", rs_data, e_rs_data);
                check("rs_rtnctl", rs_rtnctl, e_rs_rtnctl);
            end
            check("mc_rs_stall", mc_rs_stall, e_mc_rs_stall);
            check("arb_stalls", arb_stalls, m_stalls);

            g = pick();
            exp_rdy = (g < 0) ? '0 : (N'(1) << g);
            check("req_rdy", req_rdy, exp_rdy);

            if (g >= 0) begin
                grant_log.push_back(g);
                e_mc_vld = 1;
                e_cmd    = req_cmd[g*3 +: 3];
                e_scmd   = req_scmd[g*4 +: 4];
                e_size   = req_size[g*2 +: 2];
                e_vadr   = req_vadr[g*48 +: 48];
                e_data   = req_data[g*64 +: 64];
                e_rtnctl = {IW'(g), req_rtnctl[g*UW +: UW]};
                m_ptr    = (g + 1) % N;
                m_owner  = g;
                m_locked = bitof(req_lock, g);
            end else begin
                e_mc_vld = 0;
                if (m_locked && !bitof(req_lock, m_owner) && !bitof(req_vld, m_owner))
                    m_locked = 0;
            end
            if (req_vld != '0 && g < 0 && m_stalls != '1) m_stalls = m_stalls + 1;

            id = int'(mc_rs_rtnctl[RW-1 -: IW]);
            e_rs_vld = (mc_rs_vld && id < N) ? (N'(1) << id) : '0;
            if (mc_rs_vld) begin
                e_rs_cmd    = mc_rs_cmd;
                e_rs_scmd   = mc_rs_scmd;
                e_rs_data   = mc_rs_data;
                e_rs_rtnctl = mc_rs_rtnctl[UW-1:0];
            end
            e_mc_rs_stall = |rs_stall;
            m_rstall      = mc_rq_stall;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        req_vld = '0; req_lock = '0; mc_rq_stall = 0; mc_rs_vld = 0; rs_stall = '0;
        tick(); tick();
        i_reset = 1'b0;
    endtask

    task automatic fill_fields();
        for (int i = 0; i < N; i++) begin
            req_cmd[i*3 +: 3]     = 3'($urandom);
            req_scmd[i*4 +: 4]    = 4'($urandom);
            req_size[i*2 +: 2]    = 2'($urandom);
            req_vadr[i*48 +: 48]  = {16'($urandom), 32'($urandom)};
            req_data[i*64 +: 64]  = {32'($urandom), 32'($urandom)};
            req_rtnctl[i*UW +: UW] = UW'($urandom);
        end
    endtask

    int rot_exp[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int lock_exp[6] = '{2, 2, 2, 3, 0, 1};

    initial begin
        logic [63:0] s0;
        int sum;

        // single read from requester 0 and its response
        do_reset();
        check("reset_arb_stalls", arb_stalls, 64'd0);
        req_vld = 4'b0001;
        req_cmd[2:0] = MC_CMD_RD; req_scmd[3:0] = MC_SCMD_NUL; req_size[1:0] = 2'd3;
        req_vadr[47:0] = 48'h1000; req_rtnctl[UW-1:0] = UW'(5);
        tick();
        req_vld = '0;
        check("single_vld", mc_rq_vld, 1);
        check("single_rtnctl", mc_rq_rtnctl, 32'h0000_0005);
        check("single_vadr", mc_rq_vadr, 48'h1000);
        mc_rs_vld = 1; mc_rs_cmd = 3'd2; mc_rs_data = 64'hDEAD_BEEF_0000_0001;
        mc_rs_rtnctl = 32'h0000_0005;
        tick();
        mc_rs_vld = 0;
        check("single_rs_vld", rs_vld, 4'b0001);
        check("single_rs_rtnctl", rs_rtnctl, UW'(5));

        // responses to ID 3 (routed) and ID 7 (dropped), response back-pressure
        mc_rs_vld = 1; mc_rs_rtnctl = {3'd3, 29'h11};
        tick();
        mc_rs_rtnctl = {3'd7, 29'h22};
        check("rs_id3", rs_vld, 4'b1000);
        tick();
        mc_rs_vld = 0;
        check("rs_id7_dropped", rs_vld, 4'b0000);
        rs_stall = 4'b0010;
        tick();
        rs_stall = '0;
        check("mc_rs_stall_set", mc_rs_stall, 1);
        tick();
        check("mc_rs_stall_clr", mc_rs_stall, 0);

        // plain rotation, all requesters valid
        do_reset();
        grant_log.delete();
        fill_fields();
        req_vld = '1;
        repeat (8) tick();
        req_vld = '0;
        check("rot_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("rot_grant%0d", i), grant_log[i], rot_exp[i]);

        // requester 2 holds the port for three requests
        do_reset();
        grant_log.delete();
        req_vld = 4'b0100; req_lock = 4'b0100;
        tick();
        req_vld = 4'b1111;
        tick();
        req_lock = '0;
        repeat (4) tick();
        req_vld = '0;
        check("lock_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("lock_grant%0d", i), grant_log[i], lock_exp[i]);

        // MC back-pressure with one request of slack
        do_reset();
        req_vld = '1;
        repeat (3) tick();
        mc_rq_stall = 1;
        tick();
        check("stall_slack", mc_rq_vld, 1);
        s0 = arb_stalls;
        sum = 0;
        repeat (4) begin tick(); sum += int'(mc_rq_vld); end
        mc_rq_stall = 0;
        tick(); sum += int'(mc_rq_vld);
        check("stall_quiet", sum, 0);
        tick();
        check("stall_resume", mc_rq_vld, 1);
        check("stall_count", arb_stalls - s0, 64'd5);
        req_vld = '0;

        // reset while locked with a request in flight
        do_reset();
        req_vld = 4'b0001; req_lock = 4'b0001;
        tick();
        i_reset = 1'b1;
        #1;
        check("midrst_mc_rq_vld", mc_rq_vld, 0);
        check("midrst_req_rdy", req_rdy, 0);
        tick();
        i_reset = 1'b0;
        req_vld = 4'b0010; req_lock = '0;
        #1;
        check("midrst_unlocked", req_rdy, 4'b0010);
        tick();
        req_vld = '0;

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_reset      = ($urandom_range(0, 299) == 0);
            req_vld      = N'($urandom);
            req_lock     = N'($urandom & $urandom);
            fill_fields();
            mc_rq_stall  = ($urandom_range(0, 4) == 0);
            mc_rs_vld    = ($urandom_range(0, 1) == 1);
            mc_rs_cmd    = 3'($urandom);
            mc_rs_scmd   = 4'($urandom);
            mc_rs_data   = {32'($urandom), 32'($urandom)};
            mc_rs_rtnctl = RW'($urandom);
            rs_stall     = N'($urandom & $urandom & $urandom);
            tick();
        end
        i_reset = 0; req_vld = '0; mc_rs_vld = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
